pipeline_debug_ctrl: RTL and testbench

Synthesizable debug controller between a byte-stream host link and the MIPS `pipeline` core. It loads a program word-by-word into instruction memory and runs the core either free-running to HALT or one clock at a time. It also dumps PC, the register file and data memory back over the link. Word width and dump depths are parameters, so the same block serves narrower or wider core builds.

---
 rtl/pipeline_debug_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_pipeline_debug_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_debug_ctrl.sv
// pipeline_debug_ctrl: byte-stream debug controller for the MIPS pipeline core.
// Loads program words, runs or single-steps the core, and dumps PC, registers
// and data memory back to the host over a byte link.
//
// Handshake: a byte moves on any rising edge where its valid and ready are both
// high. The receiver may hold ready low. The sender keeps data stable and valid
// high until that transfer edge.
module pipeline_debug_ctrl #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 5,
    parameter int                REG_N     = 32,
    parameter int                MEM_N     = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(32'h0000_003F)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_write,
    output logic [DATA_W-1:0] o_instruction,
    output logic              o_enable,
    output logic [ADDR_W-1:0] o_debug_addr,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_reg,
    input  logic [DATA_W-1:0] i_mem,
    input  logic              i_halt,
    output logic              o_halted,
    output logic              o_cmd_err,
    output logic [2:0]        o_dbg_state
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BC_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int DUMP_N = 1 + REG_N + MEM_N;
    localparam int IDX_W  = $clog2(DUMP_N);

    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DUMP_N - 1);

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LWRITE = 3'd2,
        S_RUN    = 3'd3,
        S_STEP   = 3'd4,
        S_DSEL   = 3'd5,
        S_DWAIT  = 3'd6,
        S_DSEND  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              write_q, write_d;
    logic              enable_q, enable_d;
    logic              halted_q, halted_d;
    logic              cmd_err_q, cmd_err_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;

    logic              rx_fire;
    logic              tx_fire;
    logic [DATA_W-1:0] word_nxt;
    logic [DATA_W-1:0] shift_nxt;
    logic [DATA_W-1:0] dump_word;
    logic [IDX_W-1:0]  idx_inc;

    // Debug address for dump index k: 0 for PC, then register and memory offsets.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] off;
        if (k == '0) begin
            off = '0;
        end else if (k <= IDX_W'(REG_N)) begin
            off = k - IDX_W'(1);
        end else begin
            off = k - IDX_W'(REG_N + 1);
        end
        return ADDR_W'(off);
    endfunction

    // Ready only where a byte is consumed; held low while reset is asserted.
    assign o_rx_ready = ~i_reset & ((state_q == S_IDLE) | (state_q == S_LOAD));
    assign rx_fire    = i_rx_valid & o_rx_ready;
    assign tx_fire    = tx_valid_q & i_tx_ready;

    // Next-state and datapath logic for the whole controller.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        instr_d    = instr_q;
        write_d    = 1'b0;
        enable_d   = 1'b0;
        halted_d   = halted_q;
        cmd_err_d  = 1'b0;
        idx_d      = idx_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        word_nxt  = (word_q >> 8) | (DATA_W'(i_rx_data) << (DATA_W - 8));
        shift_nxt = shift_q >> 8;
        idx_inc   = idx_q + IDX_W'(1);
        if (idx_q == '0) begin
            dump_word = i_pc;
        end else if (idx_q <= IDX_W'(REG_N)) begin
            dump_word = i_reg;
        end else begin
            dump_word = i_mem;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_d    = S_LOAD;
                            halted_d   = 1'b0;
                            byte_cnt_d = '0;
                        end
                        CMD_RUN: begin
                            state_d  = S_RUN;
                            enable_d = ~halted_q;
                        end
                        CMD_STEP: begin
                            state_d  = S_STEP;
                            enable_d = 1'b1;
                        end
                        CMD_DUMP: begin
                            state_d = S_DSEL;
                            idx_d   = '0;
                            addr_d  = addr_of('0);
                        end
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                if (rx_fire) begin
                    word_d = word_nxt;
                    if (byte_cnt_q == BC_LAST) begin
                        byte_cnt_d = '0;
                        state_d    = S_LWRITE;
                        write_d    = 1'b1;
                        instr_d    = word_nxt;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
            end
            S_LWRITE: begin
                state_d = (instr_q == HALT_WORD) ? S_IDLE : S_LOAD;
            end
            S_RUN: begin
                // The core already sees the halt-asserted edge; drop enable after it.
                if (halted_q) begin
                    state_d = S_IDLE;
                end else if (i_halt) begin
                    halted_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    enable_d = 1'b1;
                end
            end
            S_STEP: begin
                state_d = S_IDLE;
                if (i_halt) begin
                    halted_d = 1'b1;
                end
            end
            S_DSEL: begin
                state_d = S_DWAIT;
            end
            S_DWAIT: begin
                shift_d    = dump_word;
                tx_data_d  = dump_word[7:0];
                tx_valid_d = 1'b1;
                byte_cnt_d = '0;
                state_d    = S_DSEND;
            end
            S_DSEND: begin
                if (tx_fire) begin
                    if (byte_cnt_q == BC_LAST) begin
                        tx_valid_d = 1'b0;
                        byte_cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = idx_inc;
                            addr_d  = addr_of(idx_inc);
                            state_d = S_DSEL;
                        end
                    end else begin
                        shift_d    = shift_nxt;
                        tx_data_d  = shift_nxt[7:0];
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any operation in progress.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_q     <= '0;
            instr_q    <= '0;
            write_q    <= 1'b0;
            enable_q   <= 1'b0;
            halted_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            idx_q      <= '0;
            addr_q     <= '0;
            shift_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            instr_q    <= instr_d;
            write_q    <= write_d;
            enable_q   <= enable_d;
            halted_q   <= halted_d;
            cmd_err_q  <= cmd_err_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign o_tx_data     = tx_data_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_write       = write_q;
    assign o_instruction = instr_q;
    assign o_enable      = enable_q;
    assign o_debug_addr  = addr_q;
    assign o_halted      = halted_q;
    assign o_cmd_err     = cmd_err_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Testbench for pipeline_debug_ctrl: drives host bytes, models the core
// (halt timing, one-cycle register/memory read) and checks loads, run/step
// behaviour, dump contents and reset abort against a reference model.
module tb_pipeline_debug_ctrl;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 5;
    localparam int          REG_N  = 32;
    localparam int          MEM_N  = 32;
    localparam int          BYTES  = DATA_W / 8;
    localparam logic [31:0] HALT_W = 32'h0000_003F;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_reset = 1'b1;
    logic [7:0]        i_rx_data = 8'h00;
    logic              i_rx_valid = 1'b0;
    logic              o_rx_ready;
    logic [7:0]        o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready = 1'b1;
    logic              o_write;
    logic [DATA_W-1:0] o_instruction;
    logic              o_enable;
    logic [ADDR_W-1:0] o_debug_addr;
    logic [DATA_W-1:0] i_pc;
    logic [DATA_W-1:0] i_reg;
    logic [DATA_W-1:0] i_mem;
    logic              i_halt;
    logic              o_halted;
    logic              o_cmd_err;
    logic [2:0]        o_dbg_state;

    pipeline_debug_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_N(REG_N), .MEM_N(MEM_N), .HALT_WORD(HALT_W)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_write(o_write), .o_instruction(o_instruction), .o_enable(o_enable),
        .o_debug_addr(o_debug_addr), .i_pc(i_pc), .i_reg(i_reg), .i_mem(i_mem),
        .i_halt(i_halt), .o_halted(o_halted), .o_cmd_err(o_cmd_err),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- core model ----------------
    logic [DATA_W-1:0] pc_val = 32'h0000_0040;
    logic [DATA_W-1:0] reg_rd = '0;
    logic [DATA_W-1:0] mem_rd = '0;
    int                en_total = 0;
    int                en_base = 0;
    int                halt_after = 0;
    logic              halt_arm = 1'b0;
    logic              tx_rand = 1'b0;

    assign i_pc   = pc_val;
    assign i_reg  = reg_rd;
    assign i_mem  = mem_rd;
    assign i_halt = halt_arm && ((en_total - en_base) >= halt_after);

    // reg[i] = i, mem[i] = 100 + i, one cycle of read latency
    always @(posedge clk) begin
        reg_rd <= DATA_W'(o_debug_addr);
        mem_rd <= 32'd100 + DATA_W'(o_debug_addr);
    end

    always @(posedge clk) begin
        if (o_enable) en_total <= en_total + 1;
    end

    always @(negedge clk) begin
        i_tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- monitors ----------------
    logic [31:0] got_writes[$];
    logic [7:0]  tx_got[$];
    int          overlap_err = 0;
    int          cmd_err_cnt = 0;
    int          stab_err = 0;
    logic        hold_pend = 1'b0;
    logic [7:0]  hold_val = 8'h00;

    always @(posedge clk) begin
        if (o_write) got_writes.push_back(o_instruction);
        if (o_write && o_enable) overlap_err++;
        if (o_cmd_err) cmd_err_cnt++;
        if (hold_pend && (!o_tx_valid || o_tx_data != hold_val)) stab_err++;
        hold_pend = o_tx_valid && !i_tx_ready;
        hold_val  = o_tx_data;
        if (o_tx_valid && i_tx_ready) tx_got.push_back(o_tx_data);
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [7:0]  exp_bytes[$];
    logic [31:0] load_list[$];
    int          wr_ptr = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        while (!o_rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!o_rx_ready) begin
            check("rx_ready_timeout", 64'(o_rx_ready), 64'd1);
            i_rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            i_rx_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int t;
        t = 0;
        @(negedge clk);
        while (o_dbg_state != 3'd0 && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", 64'(o_dbg_state), 64'd0);
    endtask

    // Load every word of load_list (which ends with the halt word).
    task automatic do_load();
        logic [31:0] w;
        send_byte(8'h4C);
        foreach (load_list[i]) begin
            w = load_list[i];
            for (int b = 0; b < BYTES; b++) send_byte(w[8*b +: 8]);
            @(negedge clk);
            check("write_pulse", 64'(o_write), 64'd1);
            check("write_word", 64'(o_instruction), 64'(w));
            check("ready_low_lwrite", 64'(o_rx_ready), 64'd0);
            exp_q.push_back(w);
        end
        wait_idle(10);
        check("ready_after_load", 64'(o_rx_ready), 64'd1);
    endtask

    task automatic compare_writes();
        logic [31:0] e;
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (wr_ptr < got_writes.size()) check("write_val", 64'(got_writes[wr_ptr]), 64'(e));
            else check("write_missing", 64'(got_writes.size()), 64'(wr_ptr + 1));
            wr_ptr++;
        end
        check("write_count", 64'(got_writes.size()), 64'(wr_ptr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_ready"}, 64'(o_rx_ready), 64'd0);
        check({tag, "_tx"}, {55'd0, o_tx_valid, o_tx_data}, 64'd0);
        check({tag, "_write"}, {31'd0, o_write, o_instruction}, 64'd0);
        check({tag, "_enable"}, 64'(o_enable), 64'd0);
        check({tag, "_addr"}, 64'(o_debug_addr), 64'd0);
        check({tag, "_flags"}, {62'd0, o_halted, o_cmd_err}, 64'd0);
        check({tag, "_state"}, 64'(o_dbg_state), 64'd0);
    endtask

    task automatic do_run(input int after, input int exp_en);
        halt_arm   = 1'b1;
        halt_after = after;
        en_base    = en_total;
        send_byte(8'h52);
        @(negedge clk);
        check("run_en_rise", 64'(o_enable), (exp_en > 0) ? 64'd1 : 64'd0);
        wait_idle(200);
        check("run_en_cycles", 64'(en_total - en_base), 64'(exp_en));
        check("run_halted", 64'(o_halted), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] w;
        int          cb;
        int          ha;
        int          tb0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        i_reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 64'(o_rx_ready), 64'd1);

        // directed three-word program
        load_list = '{32'h2002_0002, 32'hAC02_0002, HALT_W};
        do_load();
        compare_writes();

        // run to halt after 9 enabled edges, then a second run with halt set
        do_run(9, 10);
        en_base = en_total;
        send_byte(8'h52);
        repeat (5) @(negedge clk);
        check("rerun_en_cycles", 64'(en_total - en_base), 64'd0);
        check("rerun_state", 64'(o_dbg_state), 64'd0);

        // random programs, each followed by a random-length run
        for (int r = 0; r < 3; r++) begin
            load_list = {};
            for (int i = 0; i < 1 + r; i++) begin
                w = $urandom;
                if (w == HALT_W) w = 32'h1234_5678;
                load_list.push_back(w);
            end
            load_list.push_back(HALT_W);
            do_load();
            compare_writes();
            check("load_clears_halted", 64'(o_halted), 64'd0);
            ha = $urandom_range(0, 25);
            do_run(ha, ha + 1);
        end

        // single steps: one-cycle pulses, never consecutive
        load_list = '{HALT_W};
        do_load();
        compare_writes();
        halt_arm = 1'b0;
        en_base  = en_total;
        for (int s = 0; s < 3; s++) begin
            send_byte(8'h53);
            @(negedge clk);
            check("step_en_on", 64'(o_enable), 64'd1);
            @(negedge clk);
            check("step_en_off", 64'(o_enable), 64'd0);
        end
        check("step_count", 64'(en_total - en_base), 64'd3);
        check("step_not_halted", 64'(o_halted), 64'd0);
        halt_arm   = 1'b1;
        halt_after = 0;
        en_base    = en_total;
        send_byte(8'h53);
        wait_idle(10);
        check("step_halt_sets", 64'(o_halted), 64'd1);
        halt_arm = 1'b0;

        // dump with random tx backpressure
        pc_val = $urandom;
        exp_bytes = {};
        for (int k = 0; k < 1 + REG_N + MEM_N; k++) begin
            if (k == 0) w = pc_val;
            else if (k <= REG_N) w = 32'(k - 1);
            else w = 32'(100 + k - 1 - REG_N);
            for (int b = 0; b < BYTES; b++) exp_bytes.push_back(w[8*b +: 8]);
        end
        tb0 = tx_got.size();
        tx_rand = 1'b1;
        send_byte(8'h44);
        wait_idle(5000);
        tx_rand = 1'b0;
        check("dump_len", 64'(tx_got.size() - tb0), 64'd260);
        for (int j = 0; j < exp_bytes.size(); j++) begin
            if (tb0 + j < tx_got.size()) check("dump_byte", 64'(tx_got[tb0 + j]), 64'(exp_bytes[j]));
        end
        check("tx_stable", 64'(stab_err), 64'd0);

        // unknown command
        cb = cmd_err_cnt;
        send_byte(8'h99);
        @(negedge clk);
        check("cmd_err_pulse", 64'(o_cmd_err), 64'd1);
        check("cmd_err_state", 64'(o_dbg_state), 64'd0);
        @(negedge clk);
        check("cmd_err_clear", 64'(o_cmd_err), 64'd0);
        check("cmd_err_count", 64'(cmd_err_cnt - cb), 64'd1);
        en_base = en_total;
        send_byte(8'h53);
        wait_idle(10);
        check("cmd_after_err", 64'(en_total - en_base), 64'd1);

        // reset in the middle of a load word
        w = $urandom;
        if (w == HALT_W) w = 32'hCAFE_F00D;
        send_byte(8'h4C);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        i_reset = 1'b0;
        @(negedge clk);
        check("midreset_no_write", 64'(got_writes.size()), 64'(wr_ptr));
        load_list = '{w, HALT_W};
        do_load();
        compare_writes();

        check("write_enable_overlap", 64'(overlap_err), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
